pipeline_ctrl: RTL and testbench

// Central stall/flush/valid controller for the N-stage in-order MIPS pipeline. Generalises the fixed ihit/dhit

---
 rtl/pipeline_ctrl_pkg.sv | 23 ++
 rtl/pipeline_ctrl_sat_counter.sv | 22 ++
 rtl/pipeline_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// No logic; types only.
// Imported by pipeline_ctrl and its testbench.
package pipeline_ctrl_pkg;

    // Controller mode: normal flow, waiting on dmem, or stopped by halt.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } pctrl_state_t;

    // Which rule governs the current cycle, in priority order.
    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_HALT    = 3'd1,
        CAUSE_MEM     = 3'd2,
        CAUSE_BRANCH  = 3'd3,
        CAUSE_LOADUSE = 3'd4,
        CAUSE_IMISS   = 3'd5
    } stall_cause_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: out reflects inc one cycle later.
// Backpressure: none; holds at all-ones once saturated.
// Ports: CLK clock, clr sync clear (wins over inc), inc count enable, out count value.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] out
);

    always_ff @(posedge CLK) begin
        if (clr) begin
            out <= '0;
        end else if (inc && (out != '1)) begin
            out <= out + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/valid arbiter for an in-order pipeline; drives pipe register enables and PC enable.
// Latency: en/flush/pc_en are combinational from inputs and state; valid/halted/counters are registered.
// Backpressure: dmem miss freezes the whole pipe; imem miss bubbles IF/ID while downstream drains.
// Ports: CLK/RST (sync, active high); ihit, dhit, mem_req, br_taken, ex_dREN, ex_wsel, id_rs, id_rt,
//        wb_halt hazard inputs; pc_en, en, flush, valid, halted control outputs; cyc_cnt, stall_cnt,
//        flush_cnt saturating performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NSTAGES   = 5,
    parameter int EX_STAGE  = 2,
    parameter int MEM_STAGE = 3,
    parameter int REGW      = 5,
    parameter int CNTW      = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               mem_req,
    input  logic               br_taken,
    input  logic               ex_dREN,
    input  logic [REGW-1:0]    ex_wsel,
    input  logic [REGW-1:0]    id_rs,
    input  logic [REGW-1:0]    id_rt,
    input  logic               wb_halt,
    output logic               pc_en,
    output logic [NSTAGES-2:0] en,
    output logic [NSTAGES-2:0] flush,
    output logic [NSTAGES-2:0] valid,
    output logic               halted,
    output logic [CNTW-1:0]    cyc_cnt,
    output logic [CNTW-1:0]    stall_cnt,
    output logic [CNTW-1:0]    flush_cnt
);

    localparam int NP = NSTAGES - 1;

    pctrl_state_t state, state_nxt;
    stall_cause_t cause;

    // Stage s is valid when the register feeding it (s-1) is valid.
    logic id_vld, ex_vld, mem_vld, wb_vld;
    logic mem_stall, branch, load_use;
    logic cnt_run;
    logic [NP-1:0] valid_in;

    assign id_vld  = valid[0];
    assign ex_vld  = valid[EX_STAGE-1];
    assign mem_vld = valid[MEM_STAGE-1];
    assign wb_vld  = valid[NSTAGES-2];

    assign mem_stall = mem_vld & mem_req & ~dhit;
    assign branch    = ex_vld & br_taken;
    // r0 never carries a real dependency; ID must hold a real instruction.
    assign load_use  = ex_vld & id_vld & ex_dREN & (ex_wsel != '0) &
                       ((ex_wsel == id_rs) | (ex_wsel == id_rt));

    always_comb begin
        cause = CAUSE_NONE;
        if (state == HALTED)  cause = CAUSE_HALT;
        else if (mem_stall)   cause = CAUSE_MEM;
        else if (branch)      cause = CAUSE_BRANCH;
        else if (load_use)    cause = CAUSE_LOADUSE;
        else if (!ihit)       cause = CAUSE_IMISS;
    end

    always_comb begin
        pc_en = 1'b1;
        en    = '1;
        flush = '0;
        if (RST) begin
            pc_en = 1'b0;
            en    = '0;
            flush = '1;
        end else begin
            case (cause)
                CAUSE_HALT, CAUSE_MEM: begin
                    pc_en = 1'b0;
                    en    = '0;
                end
                CAUSE_BRANCH: begin
                    // Squash everything younger than the branch.
                    for (int k = 0; k < NP; k++) begin
                        if (k < EX_STAGE) flush[k] = 1'b1;
                    end
                end
                CAUSE_LOADUSE: begin
                    // Hold the dependent instruction and everything behind it; bubble into EX.
                    pc_en = 1'b0;
                    for (int k = 0; k < NP; k++) begin
                        if (k < EX_STAGE - 1) en[k] = 1'b0;
                    end
                    flush[EX_STAGE-1] = 1'b1;
                end
                CAUSE_IMISS: begin
                    pc_en    = 1'b0;
                    flush[0] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mem_stall)  state_nxt = MEM_WAIT;
            MEM_WAIT: if (!mem_stall) state_nxt = RUN;
            default:  state_nxt = HALTED;
        endcase
        if (wb_vld && wb_halt) state_nxt = HALTED;
    end

    // IF is always valid, so register 0 loads a constant 1.
    assign valid_in = {valid[NP-2:0], 1'b1};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            valid <= '0;
        end else begin
            state <= state_nxt;
            valid <= ~flush & ((en & valid_in) | (~en & valid));
        end
    end

    assign halted  = (state == HALTED);
    assign cnt_run = ~RST & ~halted;

    sat_counter #(.W(CNTW)) u_cyc_cnt (
        .CLK (CLK),
        .clr (RST),
        .inc (cnt_run),
        .out (cyc_cnt)
    );

    sat_counter #(.W(CNTW)) u_stall_cnt (
        .CLK (CLK),
        .clr (RST),
        .inc (cnt_run & ~pc_en),
        .out (stall_cnt)
    );

    sat_counter #(.W(CNTW)) u_flush_cnt (
        .CLK (CLK),
        .clr (RST),
        .inc (cnt_run & (cause == CAUSE_BRANCH)),
        .out (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors with hand-computed expectations.
// Stimulus pushes each cycle's expected outputs; a monitor on the falling edge pops and compares.
module tb_pipeline_ctrl;

    logic        CLK;
    logic        RST;
    logic        ihit, dhit, mem_req, br_taken, ex_dREN, wb_halt;
    logic [4:0]  ex_wsel, id_rs, id_rt;
    logic        pc_en, halted;
    logic [3:0]  en, flush, valid;
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .ihit      (ihit),
        .dhit      (dhit),
        .mem_req   (mem_req),
        .br_taken  (br_taken),
        .ex_dREN   (ex_dREN),
        .ex_wsel   (ex_wsel),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .wb_halt   (wb_halt),
        .pc_en     (pc_en),
        .en        (en),
        .flush     (flush),
        .valid     (valid),
        .halted    (halted),
        .cyc_cnt   (cyc_cnt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst, ihit, dhit, mreq, br, dren;
        logic [4:0] wsel, rs, rt;
        logic       halt;
        logic       pc;
        logic [3:0] en, fl, vl;
        logic       hlt;
        logic [31:0] cyc, stl, fc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        pc;
        logic [3:0]  en, fl, vl;
        logic        hlt;
        logic [31:0] cyc, stl, fc;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];

    function automatic vec_t mk(logic rst, logic ih, logic dh, logic mr, logic br, logic dr,
                                logic [4:0] ws, logic [4:0] rs, logic [4:0] rt, logic ht,
                                logic pc, logic [3:0] e, logic [3:0] f, logic [3:0] v, logic h,
                                logic [31:0] c, logic [31:0] s, logic [31:0] fc);
        vec_t t;
        t.rst = rst; t.ihit = ih; t.dhit = dh; t.mreq = mr; t.br = br; t.dren = dr;
        t.wsel = ws; t.rs = rs; t.rt = rt; t.halt = ht;
        t.pc = pc; t.en = e; t.fl = f; t.vl = v; t.hlt = h; t.cyc = c; t.stl = s; t.fc = fc;
        return t;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_en",     e.idx, {31'b0, pc_en},  {31'b0, e.pc});
                chk("en",        e.idx, {28'b0, en},     {28'b0, e.en});
                chk("flush",     e.idx, {28'b0, flush},  {28'b0, e.fl});
                chk("valid",     e.idx, {28'b0, valid},  {28'b0, e.vl});
                chk("halted",    e.idx, {31'b0, halted}, {31'b0, e.hlt});
                chk("cyc_cnt",   e.idx, cyc_cnt,         e.cyc);
                chk("stall_cnt", e.idx, stall_cnt,       e.stl);
                chk("flush_cnt", e.idx, flush_cnt,       e.fc);
            end
        end
    end

    initial begin
        vec_t v;
        exp_t e;
        //               rst ih dh mr br dr ws rs rt ht | pc  en     fl     vl    h  cyc stl fc
        // Reset, then fill the pipe.
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'h0, 4'hF, 4'h0, 0,  0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'h0, 4'hF, 4'h0, 0,  0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h0, 0,  0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h1, 0,  1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h3, 0,  2, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h7, 0,  3, 0, 0));
        // dmem miss for 3 cycles, released on dhit.
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0,   0, 4'h0, 4'h0, 4'hF, 0,  4, 0, 0));
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0,   0, 4'h0, 4'h0, 4'hF, 0,  5, 1, 0));
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0,   0, 4'h0, 4'h0, 4'hF, 0,  6, 2, 0));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'hF, 0,  7, 3, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'hF, 0,  8, 3, 0));
        // Load-use on rs, then refill.
        vq.push_back(mk(0, 1, 0, 0, 0, 1, 8, 8, 0, 0,   0, 4'hE, 4'h2, 4'hF, 0,  9, 3, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'hD, 0, 10, 4, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'hB, 0, 11, 4, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h7, 0, 12, 4, 0));
        // Load to r0 never stalls.
        vq.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'hF, 0, 13, 4, 0));
        // Load-use on rt.
        vq.push_back(mk(0, 1, 0, 0, 0, 1, 5, 3, 5, 0,   0, 4'hE, 4'h2, 4'hF, 0, 14, 4, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'hD, 0, 15, 5, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'hB, 0, 16, 5, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h7, 0, 17, 5, 0));
        // Taken branch; second br_taken arrives with EX invalid and is ignored.
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0,   1, 4'hF, 4'h3, 4'hF, 0, 18, 5, 0));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'hC, 0, 19, 5, 1));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h9, 0, 20, 5, 1));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h3, 0, 21, 5, 1));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h7, 0, 22, 5, 1));
        // Branch during dmem miss: freeze first, flush on the release cycle.
        vq.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0,   0, 4'h0, 4'h0, 4'hF, 0, 23, 5, 1));
        vq.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0,   1, 4'hF, 4'h3, 4'hF, 0, 24, 6, 1));
        // imem miss: bubble into IF/ID, downstream drains.
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'hF, 4'h1, 4'hC, 0, 25, 6, 2));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h8, 0, 26, 7, 2));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h1, 0, 27, 7, 2));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h3, 0, 28, 7, 2));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h7, 0, 29, 7, 2));
        // Halt in WB: sticky, everything frozen, cleared only by reset.
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1,   1, 4'hF, 4'h0, 4'hF, 0, 30, 7, 2));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'h0, 4'h0, 4'hF, 1, 31, 7, 2));
        vq.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0,   0, 4'h0, 4'h0, 4'hF, 1, 31, 7, 2));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'h0, 4'hF, 4'hF, 1, 31, 7, 2));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h0, 0,  0, 0, 0));
        // wb_halt with WB invalid is ignored.
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1,   1, 4'hF, 4'h0, 4'h1, 0,  1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'hF, 4'h0, 4'h3, 0,  2, 0, 0));

        RST = 1'b1; ihit = 1'b0; dhit = 1'b0; mem_req = 1'b0; br_taken = 1'b0;
        ex_dREN = 1'b0; ex_wsel = '0; id_rs = '0; id_rt = '0; wb_halt = 1'b0;
        @(posedge CLK);
        for (int i = 0; i < vq.size(); i++) begin
            #1;
            v = vq[i];
            RST = v.rst; ihit = v.ihit; dhit = v.dhit; mem_req = v.mreq; br_taken = v.br;
            ex_dREN = v.dren; ex_wsel = v.wsel; id_rs = v.rs; id_rt = v.rt; wb_halt = v.halt;
            e.idx = i; e.pc = v.pc; e.en = v.en; e.fl = v.fl; e.vl = v.vl; e.hlt = v.hlt;
            e.cyc = v.cyc; e.stl = v.stl; e.fc = v.fc;
            sb.push_back(e);
            @(posedge CLK);
        end
        repeat (3) @(posedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
